// File: rtl/tt_zbuf_seq.sv
// Zeroing-buffer enable sequencer for one slot: input gates open before output gates and close after them.
// Optional build macro TT_ZBUF_SEQ_SYNC_EN adds 2-flop synchronizers on en_req and force_off.
module tt_zbuf_seq #(
  parameter int unsigned GUARD_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic               force_off,
  input  logic [GUARD_W-1:0] guard_cfg,
  output logic               zbuf_e_in,
  output logic               zbuf_e_out,
  output logic               en_ack,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARM   = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [GUARD_W-1:0] cnt, cnt_nxt;
  logic               en_s;
  logic               fo_s;
  logic               e_in_nxt;
  logic               e_out_nxt;
  logic               busy_nxt;

`ifdef TT_ZBUF_SEQ_SYNC_EN
  logic [1:0] en_sync;
  logic [1:0] fo_sync;

  // Two-stage synchronizers for the asynchronous control requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync <= 2'b00;
      fo_sync <= 2'b00;
    end else begin
      en_sync <= {en_sync[0], en_req};
      fo_sync <= {fo_sync[0], force_off};
    end
  end

  assign en_s = en_sync[1];
  assign fo_s = fo_sync[1];
`else
  assign en_s = en_req;
  assign fo_s = force_off;
`endif

  // State, guard counter and registered enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      zbuf_e_in  <= 1'b0;
      zbuf_e_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      zbuf_e_in  <= e_in_nxt;
      zbuf_e_out <= e_out_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic; guard_cfg is only looked at when the counter is loaded
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;

    if (fo_s) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          cnt_nxt = '0;
          if (en_s) begin
            state_nxt = ST_ARM;
            cnt_nxt   = guard_cfg;
          end
        end
        ST_ARM: begin
          if (!en_s) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = ST_ON;
          end else begin
            cnt_nxt = cnt - GUARD_W'(1);
          end
        end
        ST_ON: begin
          if (!en_s) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = guard_cfg;
          end
        end
        ST_DRAIN: begin
          // A new request during drain waits until OFF is reached
          if (cnt == '0) begin
            state_nxt = ST_OFF;
          end else begin
            cnt_nxt = cnt - GUARD_W'(1);
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end

    e_in_nxt  = (state_nxt != ST_OFF);
    e_out_nxt = (state_nxt == ST_ON);
    busy_nxt  = (state_nxt == ST_ARM) || (state_nxt == ST_DRAIN);
  end

  assign en_ack = zbuf_e_out;

  // Output gates must never be open while input gates are closed
  a_order: assert property (@(posedge clk) disable iff (!rst_n) !(zbuf_e_out && !zbuf_e_in));
  a_busy:  assert property (@(posedge clk) disable iff (!rst_n)
                            busy == ((state == ST_ARM) || (state == ST_DRAIN)));

endmodule
